error_alert_ctrl: RTL and testbench
===================================

# error_alert_ctrl

Consumer side of the error-threshold monitor's interrupt outputs: captures per-source interrupt pulses, arbitrates them into an event FIFO the host drains over a valid/ready port, keeps a W1C sticky status, and drives the DDR5 RCD ALERT_n pin with bounded low pulses. Fatal events latch ALERT_n low until explicit host acknowledge. Sits between the monitor's `interrupt_per_source` / `source_fatal` outputs and the host register block / pad ring.

## Interface
- NUM_SOURCES, 8, number of interrupt sources (2..32)
- FIFO_DEPTH, 8, event FIFO entries (power of two, ≥2)
- ALERT_PULSE_CYCLES, 16, ALERT_n low width per non-fatal alert (≥1)
- ALERT_GAP_CYCLES, 4, minimum ALERT_n high time between pulses (≥1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  gates capture and FIFO push; pop, FSM, W1C keep running
- irq_in  in  NUM_SOURCES  per-source interrupt pulses
- src_fatal  in  NUM_SOURCES  per-source fatal qualifier, sampled with irq_in
- irq_mask  in  NUM_SOURCES  1 = ignore source
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  host pop; pop when evt_valid & evt_ready
- evt_src_id  out  $clog2(NUM_SOURCES)  head entry source index
- evt_fatal  out  1  head entry fatal flag
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- sticky_status  out  NUM_SOURCES  set on any unmasked capture
- sts_clr  in  NUM_SOURCES  W1C pulse for sticky_status
- lost_count  out  8  saturating count of coalesced events
- fatal_ack  in  1  releases fatal ALERT hold
- alert_n  out  1  registered ALERT pin drive, active-low
- alert_busy  out  1  FSM not IDLE

## Operation
- Capture (enable=1): cap = irq_in & ~irq_mask; pending |= cap; pending_fatal[i] |= src_fatal[i] on capture.
- Coalesce: cap[i] while pending[i] already set and source i not pushed that cycle → lost_count +1 per such source-cycle, saturates at 8'hFF.
- Push: when pending≠0 and fifo_count<FIFO_DEPTH, lowest-index pending source written as {pending_fatal[i], i}; pending[i], pending_fatal[i] cleared. One push per cycle. Full blocks push even if a pop occurs the same cycle. Capture on source being pushed the same cycle re-sets pending (not lost).
- Pop: head removed on evt_valid & evt_ready; evt_src_id/evt_fatal are don't-care (drive 0) when empty.
- sticky_status: set by cap, cleared by sts_clr; set wins on same-cycle conflict.
- Every push sets alert_req; a fatal push also sets fatal_req.
- FSM states IDLE, ASSERT, GAP, FATAL:
  - IDLE: fatal_req → FATAL; else alert_req → ASSERT (clears alert_req, loads counter ALERT_PULSE_CYCLES-1).
  - ASSERT: counter down; at 0 → GAP (load ALERT_GAP_CYCLES-1); fatal_req → FATAL immediately.
  - GAP: counter down; at 0 → IDLE; fatal_req → FATAL immediately.
  - FATAL: hold; fatal_ack → GAP, clears fatal_req and alert_req. Fatal pushes during FATAL are absorbed.
- alert_n = 0 in ASSERT and FATAL, 1 otherwise; registered from next-state.
- enable=0: no capture, no push; pending held.

## Timing
- Reset: alert_n=1, evt_valid=0, fifo_count=0, sticky_status=0, lost_count=0, alert_busy=0, FSM IDLE, pending/req flags 0, FIFO pointers 0. Mid-operation reset discards all state asynchronously.
- irq_in at cycle N → pending N+1 → push end of N+1 → evt_valid and fifo_count=1 at N+2.
- FSM IDLE → alert_n low from N+3 for exactly ALERT_PULSE_CYCLES cycles, then high ≥ ALERT_GAP_CYCLES.
- Fatal path: alert_n low from N+3, held until cycle after fatal_ack sampled, then high ≥ ALERT_GAP_CYCLES.
- Pop visible: fifo_count decrements cycle after handshake; push+pop same cycle (not full) leaves count unchanged.
- sticky_status updates the cycle after irq_in / sts_clr.

## Structure
- Package err_alert_pkg: alert_state_e (IDLE, ASSERT, GAP, FATAL), evt_entry_t packed struct {fatal, src_id}, default pulse/gap localparams.
- Sub-module err_evt_fifo: synchronous FIFO of evt_entry_t, push/pop/full/empty/count, no bypass.
- Top holds capture, priority encoder, sticky/lost logic, ALERT FSM.

## Test plan
- irq_in=8'h04 one cycle, mask 0 → evt_src_id=2, evt_fatal=0 at N+2; alert_n low N+3..N+18, high ≥4 cycles; sticky_status=8'h04.
- irq_in=8'h81 one cycle → two pushes, source 0 then 7; one alert pulse per push separated by 4-cycle gap; fifo_count reaches 2.
- evt_ready=0, nine single-source irqs on distinct cycles to sources 0..7 then 0 again → fifo_count=8, source 0 held pending; pop once → source 0 pushed next cycle, lost_count=0.
- Same source irq on two consecutive cycles with FIFO full → lost_count=1; lost_count saturates at 255 after 300 such events.
- irq_in[3]=1 with src_fatal[3]=1 during an ASSERT pulse → alert_n stays low indefinitely; fatal_ack → alert_n high next cycle for 4-cycle gap, alert_busy drops after gap.
- sts_clr=8'h04 same cycle as irq_in[2] → sticky bit 2 stays 1; rst_n low mid-ASSERT → alert_n=1, fifo_count=0 immediately.

Source files
------------

// File: rtl/err_alert_pkg.sv
// Shared types for the error alert controller.
//   alert_state_e : ALERT_n sequencing states
//   evt_entry_t   : one event FIFO entry {fatal, src_id}; src_id is sized for
//                   the largest supported source count (32) and narrowed at the top.
package err_alert_pkg;

    localparam int MAX_SRC_ID_W           = 5;
    localparam int DEF_ALERT_PULSE_CYCLES = 16;
    localparam int DEF_ALERT_GAP_CYCLES   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2,
        FATAL  = 2'd3
    } alert_state_e;

    typedef struct packed {
        logic                    fatal;
        logic [MAX_SRC_ID_W-1:0] src_id;
    } evt_entry_t;

endpackage

// File: rtl/err_evt_fifo.sv
// Synchronous event FIFO (no bypass: a pushed entry is visible the cycle after).
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push/wr_data : write request and entry; ignored when full
//   pop          : read request; ignored when empty
//   rd_data      : head entry (undefined when empty)
//   full, empty, count : occupancy status
module err_evt_fifo
    import err_alert_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  evt_entry_t                 wr_data,
    input  logic                       pop,
    output evt_entry_t                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    evt_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/error_alert_ctrl.sv
// Error alert controller: captures per-source interrupt pulses into a pending
// set, pushes the lowest pending source into an event FIFO each cycle, keeps a
// W1C sticky status and a saturating lost-event counter, and sequences the
// active-low ALERT_n pin (bounded pulses, fatal hold until acknowledged).
//   irq_in/src_fatal/irq_mask : interrupt pulses, fatal qualifier, mask
//   evt_valid/evt_ready/evt_src_id/evt_fatal/fifo_count : host event port
//   sticky_status/sts_clr     : sticky capture status, write-1-to-clear
//   lost_count                : coalesced events, saturating at 255
//   fatal_ack/alert_n/alert_busy : ALERT pin control
module error_alert_ctrl
    import err_alert_pkg::*;
#(
    parameter int NUM_SOURCES        = 8,
    parameter int FIFO_DEPTH         = 8,
    parameter int ALERT_PULSE_CYCLES = DEF_ALERT_PULSE_CYCLES,
    parameter int ALERT_GAP_CYCLES   = DEF_ALERT_GAP_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [NUM_SOURCES-1:0]           irq_in,
    input  logic [NUM_SOURCES-1:0]           src_fatal,
    input  logic [NUM_SOURCES-1:0]           irq_mask,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [$clog2(NUM_SOURCES)-1:0]   evt_src_id,
    output logic                             evt_fatal,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic [NUM_SOURCES-1:0]           sticky_status,
    input  logic [NUM_SOURCES-1:0]           sts_clr,
    output logic [7:0]                       lost_count,
    input  logic                             fatal_ack,
    output logic                             alert_n,
    output logic                             alert_busy
);

    localparam int SRC_W   = $clog2(NUM_SOURCES);
    localparam int TMR_MAX = (ALERT_PULSE_CYCLES > ALERT_GAP_CYCLES) ?
                             ALERT_PULSE_CYCLES : ALERT_GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    function automatic logic [5:0] popcount(input logic [NUM_SOURCES-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [5:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {3'b000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [NUM_SOURCES-1:0] cap;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] pending_fatal;
    logic [NUM_SOURCES-1:0] push_onehot;
    logic [NUM_SOURCES-1:0] coalesce;
    logic [SRC_W-1:0]       push_idx;
    logic                   push_en;
    logic                   fatal_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    evt_entry_t             push_entry;
    evt_entry_t             head_entry;
    logic [MAX_SRC_ID_W-1:0] unused_head_src;

    alert_state_e           state, state_nxt;
    logic [TMR_W-1:0]       tmr, tmr_nxt;
    logic                   alert_req, alert_req_nxt;
    logic                   fatal_req, fatal_req_nxt;
    logic                   alert_clr;
    logic                   ack_clr;

    // ---- capture / arbitration ----
    assign cap = enable ? (irq_in & ~irq_mask) : '0;

    always_comb begin
        push_idx = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (pending[i]) push_idx = SRC_W'(i);
        end
    end

    assign push_en           = enable & (|pending) & ~fifo_full;
    assign push_onehot       = push_en ? (NUM_SOURCES'(1) << push_idx) : '0;
    // A capture on the source being pushed this cycle simply re-arms it.
    assign coalesce          = cap & pending & ~push_onehot;
    assign push_entry.fatal  = pending_fatal[push_idx];
    assign push_entry.src_id = MAX_SRC_ID_W'(push_idx);
    assign fatal_push        = push_en & push_entry.fatal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            pending_fatal <= '0;
            sticky_status <= '0;
            lost_count    <= '0;
        end else begin
            pending       <= (pending & ~push_onehot) | cap;
            pending_fatal <= (pending_fatal & ~push_onehot) | (cap & src_fatal);
            sticky_status <= (sticky_status & ~sts_clr) | cap;
            lost_count    <= sat_add8(lost_count, popcount(coalesce));
        end
    end

    // ---- event FIFO / host port ----
    err_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_en),
        .wr_data (push_entry),
        .pop     (evt_ready),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign unused_head_src = head_entry.src_id;
    assign evt_valid  = ~fifo_empty;
    assign evt_src_id = fifo_empty ? '0 : head_entry.src_id[SRC_W-1:0];
    assign evt_fatal  = fifo_empty ? 1'b0 : head_entry.fatal;

    // ---- ALERT_n sequencer ----
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        alert_clr = 1'b0;
        ack_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (fatal_req) begin
                    state_nxt = FATAL;
                end else if (alert_req) begin
                    state_nxt = ASSERT;
                    tmr_nxt   = TMR_W'(ALERT_PULSE_CYCLES - 1);
                    alert_clr = 1'b1;
                end
            end
            ASSERT: begin
                if (fatal_req) begin
                    state_nxt = FATAL;
                end else if (tmr == '0) begin
                    state_nxt = GAP;
                    tmr_nxt   = TMR_W'(ALERT_GAP_CYCLES - 1);
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            GAP: begin
                if (fatal_req) begin
                    state_nxt = FATAL;
                end else if (tmr == '0) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            FATAL: begin
                if (fatal_ack) begin
                    state_nxt = GAP;
                    tmr_nxt   = TMR_W'(ALERT_GAP_CYCLES - 1);
                    ack_clr   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A push in the same cycle the FSM consumes alert_req still queues a pulse;
        // the acknowledge wipes everything raised while the pin was held.
        alert_req_nxt = ack_clr ? 1'b0 : ((alert_req & ~alert_clr) | push_en);
        fatal_req_nxt = ack_clr ? 1'b0 : (fatal_req | fatal_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            alert_req <= 1'b0;
            fatal_req <= 1'b0;
            alert_n   <= 1'b1;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            alert_req <= alert_req_nxt;
            fatal_req <= fatal_req_nxt;
            alert_n   <= ~((state_nxt == ASSERT) || (state_nxt == FATAL));
        end
    end

    assign alert_busy = (state != IDLE);

endmodule

// File: tb/tb_error_alert_ctrl.sv
// Self-checking bench for error_alert_ctrl: table-driven single-capture
// vectors, a scoreboard of expected FIFO entries checked on every host pop,
// and hand-written sequences for ALERT_n timing, FIFO full, lost-count
// saturation, the fatal hold, W1C conflicts and asynchronous reset.
module tb_error_alert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] irq_in = '0;
    logic [7:0] src_fatal = '0;
    logic [7:0] irq_mask = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_src_id;
    logic       evt_fatal;
    logic [3:0] fifo_count;
    logic [7:0] sticky_status;
    logic [7:0] sts_clr = '0;
    logic [7:0] lost_count;
    logic       fatal_ack = 1'b0;
    logic       alert_n;
    logic       alert_busy;

    error_alert_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .irq_in        (irq_in),
        .src_fatal     (src_fatal),
        .irq_mask      (irq_mask),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_src_id    (evt_src_id),
        .evt_fatal     (evt_fatal),
        .fifo_count    (fifo_count),
        .sticky_status (sticky_status),
        .sts_clr       (sts_clr),
        .lost_count    (lost_count),
        .fatal_ack     (fatal_ack),
        .alert_n       (alert_n),
        .alert_busy    (alert_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fatal;
        logic [2:0] id;
    } sb_t;

    typedef struct {
        logic [7:0] irq;
        logic [7:0] fat;
        logic [7:0] mask;
        logic       en;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic       exp_fatal;
        logic [3:0] exp_count;
        logic [7:0] exp_sticky;
    } vec_t;

    sb_t  exp_q[$];
    vec_t vt[8];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push_bits(input logic [7:0] bits, input logic [7:0] fat);
        for (int i = 0; i < 8; i++) begin
            if (bits[i]) exp_q.push_back({fat[i], 3'(i)});
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        irq_in    = '0;
        src_fatal = '0;
        irq_mask  = '0;
        sts_clr   = '0;
        evt_ready = 1'b0;
        fatal_ack = 1'b0;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // Scoreboard: every accepted pop must match the oldest expected entry.
    always begin
        sb_t e;
        @(negedge clk);
        #1;
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_pop: got src %0d, expected no entry", evt_src_id);
            end else begin
                e = exp_q.pop_front();
                check("sb_src_id", 32'(evt_src_id), 32'(e.id));
                check("sb_fatal", 32'(evt_fatal), 32'(e.fatal));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_an;
        logic exp_bz;

        vt[0] = '{8'h04, 8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 4'd1, 8'h04};
        vt[1] = '{8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 3'd4, 1'b1, 4'd1, 8'h10};
        vt[2] = '{8'h04, 8'h00, 8'h04, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00};
        vt[3] = '{8'h81, 8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 4'd1, 8'h81};
        vt[4] = '{8'h60, 8'h40, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 4'd1, 8'h60};
        vt[5] = '{8'h80, 8'h80, 8'h01, 1'b1, 1'b1, 3'd7, 1'b1, 4'd1, 8'h80};
        vt[6] = '{8'h0F, 8'h01, 8'h0E, 1'b1, 1'b1, 3'd0, 1'b1, 4'd1, 8'h01};
        vt[7] = '{8'h04, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00};

        // Reset state
        step(2);
        check("rst_alert_n", 32'(alert_n), 32'd1);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_sticky", 32'(sticky_status), 32'd0);
        check("rst_lost", 32'(lost_count), 32'd0);
        check("rst_busy", 32'(alert_busy), 32'd0);

        // Table-driven single-cycle captures
        foreach (vt[v]) begin
            do_reset();
            enable    = vt[v].en;
            irq_mask  = vt[v].mask;
            irq_in    = vt[v].irq;
            src_fatal = vt[v].fat;
            if (vt[v].en) sb_push_bits(vt[v].irq & ~vt[v].mask, vt[v].fat);
            step();
            irq_in    = '0;
            src_fatal = '0;
            check($sformatf("vec%0d_sticky", v), 32'(sticky_status), 32'(vt[v].exp_sticky));
            step();
            check($sformatf("vec%0d_valid", v), 32'(evt_valid), 32'(vt[v].exp_valid));
            check($sformatf("vec%0d_src_id", v), 32'(evt_src_id), 32'(vt[v].exp_id));
            check($sformatf("vec%0d_fatal", v), 32'(evt_fatal), 32'(vt[v].exp_fatal));
            check($sformatf("vec%0d_count", v), 32'(fifo_count), 32'(vt[v].exp_count));
            evt_ready = 1'b1;
            step(6);
            evt_ready = 1'b0;
            check($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 32'd0);
            check($sformatf("vec%0d_count_end", v), 32'(fifo_count), 32'd0);
        end

        // Single non-fatal alert pulse: low N+3..N+18, gap through N+22
        do_reset();
        irq_in = 8'h04;
        step();
        irq_in = '0;
        for (int k = 1; k <= 24; k++) begin
            exp_an = !(k >= 3 && k <= 18);
            exp_bz = (k >= 3 && k <= 22);
            check($sformatf("pulse1_alert_n_k%0d", k), 32'(alert_n), 32'(exp_an));
            check($sformatf("pulse1_busy_k%0d", k), 32'(alert_busy), 32'(exp_bz));
            step();
        end

        // Two sources in one cycle: two pushes, two pulses separated by the gap
        do_reset();
        irq_in = 8'h81;
        sb_push_bits(8'h81, 8'h00);
        step();
        irq_in = '0;
        for (int k = 1; k <= 42; k++) begin
            exp_an = !((k >= 3 && k <= 18) || (k >= 24 && k <= 39));
            check($sformatf("pulse2_alert_n_k%0d", k), 32'(alert_n), 32'(exp_an));
            if (k == 2) check("pulse2_count_k2", 32'(fifo_count), 32'd1);
            if (k == 3) check("pulse2_count_k3", 32'(fifo_count), 32'd2);
            step();
        end

        // FIFO full: source 0 waits in pending, pushed the cycle after a pop
        do_reset();
        for (int i = 0; i < 9; i++) begin
            irq_in = 8'(1 << (i % 8));
            sb_push_bits(8'(1 << (i % 8)), 8'h00);
            step();
        end
        irq_in = '0;
        step(2);
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_head", 32'(evt_src_id), 32'd0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("full_count_after_pop", 32'(fifo_count), 32'd7);
        step();
        check("full_count_refill", 32'(fifo_count), 32'd8);
        check("full_lost", 32'(lost_count), 32'd0);
        evt_ready = 1'b1;
        step(10);
        evt_ready = 1'b0;
        check("full_drained", 32'(exp_q.size()), 32'd0);
        check("full_count_end", 32'(fifo_count), 32'd0);

        // Lost events while full, saturating at 255
        do_reset();
        for (int i = 0; i < 8; i++) begin
            irq_in = 8'(1 << i);
            step();
        end
        irq_in = 8'h08;
        for (int n = 1; n <= 302; n++) begin
            step();
            if (n == 1)   check("lost_first", 32'(lost_count), 32'd0);
            if (n == 2)   check("lost_one", 32'(lost_count), 32'd1);
            if (n == 255) check("lost_254", 32'(lost_count), 32'd254);
            if (n == 256) check("lost_255", 32'(lost_count), 32'd255);
        end
        irq_in = '0;
        check("lost_saturated", 32'(lost_count), 32'd255);
        check("lost_count_full", 32'(fifo_count), 32'd8);

        // Fatal event during an ASSERT pulse holds ALERT_n until acknowledged
        do_reset();
        evt_ready = 1'b1;
        irq_in = 8'h04;
        sb_push_bits(8'h04, 8'h00);
        step();
        irq_in = '0;
        step(5);
        check("fatal_in_assert", 32'(alert_n), 32'd0);
        irq_in    = 8'h08;
        src_fatal = 8'h08;
        sb_push_bits(8'h08, 8'h08);
        step();
        irq_in    = '0;
        src_fatal = '0;
        step(30);
        check("fatal_hold_alert_n", 32'(alert_n), 32'd0);
        check("fatal_hold_busy", 32'(alert_busy), 32'd1);
        fatal_ack = 1'b1;
        step();
        fatal_ack = 1'b0;
        check("fatal_ack_alert_n", 32'(alert_n), 32'd1);
        check("fatal_ack_busy", 32'(alert_busy), 32'd1);
        for (int g = 1; g <= 3; g++) begin
            step();
            check($sformatf("fatal_gap%0d_alert_n", g), 32'(alert_n), 32'd1);
            check($sformatf("fatal_gap%0d_busy", g), 32'(alert_busy), 32'd1);
        end
        step();
        check("fatal_idle_busy", 32'(alert_busy), 32'd0);
        step(5);
        check("fatal_idle_alert_n", 32'(alert_n), 32'd1);
        check("fatal_idle_busy_late", 32'(alert_busy), 32'd0);
        check("fatal_drained", 32'(exp_q.size()), 32'd0);

        // W1C sticky status: set wins over a same-cycle clear
        do_reset();
        evt_ready = 1'b1;
        irq_in = 8'h04;
        sb_push_bits(8'h04, 8'h00);
        step();
        irq_in = '0;
        check("sticky_set", 32'(sticky_status), 32'h04);
        irq_in  = 8'h04;
        sts_clr = 8'h04;
        sb_push_bits(8'h04, 8'h00);
        step();
        irq_in  = '0;
        sts_clr = '0;
        check("sticky_set_wins", 32'(sticky_status), 32'h04);
        sts_clr = 8'h04;
        step();
        sts_clr = '0;
        check("sticky_cleared", 32'(sticky_status), 32'h00);
        irq_in = 8'h30;
        sb_push_bits(8'h30, 8'h00);
        step();
        irq_in  = '0;
        sts_clr = 8'h10;
        step();
        sts_clr = '0;
        check("sticky_partial_clr", 32'(sticky_status), 32'h20);

        // Asynchronous reset in the middle of an ASSERT pulse
        do_reset();
        irq_in = 8'h04;
        step();
        irq_in = '0;
        step(5);
        check("midrst_pre_alert_n", 32'(alert_n), 32'd0);
        check("midrst_pre_count", 32'(fifo_count), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_alert_n", 32'(alert_n), 32'd1);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_valid", 32'(evt_valid), 32'd0);
        check("midrst_busy", 32'(alert_busy), 32'd0);
        check("midrst_sticky", 32'(sticky_status), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("midrst_after_alert_n", 32'(alert_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
